// File: rtl/id_ex_stage_reg_s_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_s_pkg
// Shared types and constants for the ID/EX pipeline boundary register.
//   - id_ex_bundle_t      : packed decoded-instruction bundle
//   - ID_EX_BUNDLE_RESET  : all-zero bundle used as the reset value
//   - skid_state_t        : occupancy states of the 1-entry skid buffer
//   - OP_*                : RV32 major opcodes used by decode/execute
// ---------------------------------------------------------------------------
package id_ex_stage_reg_s_pkg;

    localparam int ID_EX_XLEN   = 32;
    localparam int ID_EX_REG_AW = 5;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // EMPTY: main invalid; FULL: main valid; SKID: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    // Field order is significant: it defines the packed bit layout.
    typedef struct packed {
        logic [6:0]              op;
        logic [2:0]              funct3;
        logic [6:0]              funct7;
        logic                    mem_read;
        logic                    mem_write;
        logic                    reg_write;
        logic                    jump;
        logic                    branch;
        logic [ID_EX_REG_AW-1:0] rs1;
        logic [ID_EX_REG_AW-1:0] rs2;
        logic [ID_EX_REG_AW-1:0] rd;
        logic [ID_EX_XLEN-1:0]   rs1_data;
        logic [ID_EX_XLEN-1:0]   rs2_data;
        logic [ID_EX_XLEN-1:0]   imm;
        logic [ID_EX_XLEN-1:0]   pc;
    } id_ex_bundle_t;

    localparam id_ex_bundle_t ID_EX_BUNDLE_RESET = '0;
    localparam int            ID_EX_BUNDLE_W     = $bits(id_ex_bundle_t);

endpackage

// File: rtl/id_ex_stage_reg_s_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf_s
// Generic valid/ready register slice with a 1-entry skid buffer and flush.
// in_ready depends only on registered state, so downstream back-pressure
// never forms a combinational path to the upstream stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           invalidate both entries; same-cycle offer is dropped
//   in_valid/ready  upstream handshake, in_data payload (W bits)
//   out_valid/ready downstream handshake, out_data payload (main register)
// ---------------------------------------------------------------------------
module pipe_skid_buf_s
    import id_ex_stage_reg_s_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  r_state;
    logic [W-1:0] r_m_data;
    logic [W-1:0] r_s_data;

    logic w_accept;
    logic w_drain;

    assign in_ready  = (r_state != ST_SKID);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_m_data;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_m_data <= RST_VAL;
            r_s_data <= RST_VAL;
        end else if (flush) begin
            // Data registers keep stale values; consumers mask on valid.
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_m_data <= in_data;
                        r_state  <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_drain) begin
                        r_m_data <= in_data;
                    end else if (w_accept) begin
                        r_s_data <= in_data;
                        r_state  <= ST_SKID;
                    end else if (w_drain) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_drain) begin
                        r_m_data <= r_s_data;
                        r_state  <= ST_FULL;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage_reg_s.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_s
// ID/EX pipeline boundary register. Captures the decoded bundle on accept and
// presents it to execute one cycle later through a skid buffer. Control bits
// are forced to zero whenever no valid bundle is held, so a bubble can never
// write memory, write a register, or redirect the PC.
// Ports:
//   clk, rst, flush          clock, sync active-high reset, redirect flush
//   in_valid / in_ready      decode-side handshake
//   in_* fields              decoded bundle from control unit / regfile
//   out_valid / out_ready    execute-side handshake
//   out_* fields             registered copy of the in_* fields
// ---------------------------------------------------------------------------
module id_ex_stage_reg_s
    import id_ex_stage_reg_s_pkg::*;
#(
    parameter int XLEN   = ID_EX_XLEN,
    parameter int REG_AW = ID_EX_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_jump,
    input  logic              in_branch,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        out_op,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_jump,
    output logic              out_branch,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc
);

    id_ex_bundle_t w_in_bundle;
    id_ex_bundle_t w_m_bundle;
    logic          w_m_valid;

    assign w_in_bundle = '{
        op:        in_op,
        funct3:    in_funct3,
        funct7:    in_funct7,
        mem_read:  in_mem_read,
        mem_write: in_mem_write,
        reg_write: in_reg_write,
        jump:      in_jump,
        branch:    in_branch,
        rs1:       in_rs1,
        rs2:       in_rs2,
        rd:        in_rd,
        rs1_data:  in_rs1_data,
        rs2_data:  in_rs2_data,
        imm:       in_imm,
        pc:        in_pc
    };

    pipe_skid_buf_s #(
        .W       (ID_EX_BUNDLE_W),
        .RST_VAL (ID_EX_BUNDLE_RESET)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_bundle),
        .out_valid (w_m_valid),
        .out_ready (out_ready),
        .out_data  (w_m_bundle)
    );

    assign out_valid = w_m_valid;

    // Control bits come straight from the main register, gated by its valid
    // bit: invalidating the entry (drain, flush) clears them at the output.
    assign out_mem_read  = w_m_bundle.mem_read  & w_m_valid;
    assign out_mem_write = w_m_bundle.mem_write & w_m_valid;
    assign out_reg_write = w_m_bundle.reg_write & w_m_valid;
    assign out_jump      = w_m_bundle.jump      & w_m_valid;
    assign out_branch    = w_m_bundle.branch    & w_m_valid;

    // Data fields may be stale in a bubble.
    assign out_op       = w_m_bundle.op;
    assign out_funct3   = w_m_bundle.funct3;
    assign out_funct7   = w_m_bundle.funct7;
    assign out_rs1      = w_m_bundle.rs1;
    assign out_rs2      = w_m_bundle.rs2;
    assign out_rd       = w_m_bundle.rd;
    assign out_rs1_data = w_m_bundle.rs1_data;
    assign out_rs2_data = w_m_bundle.rs2_data;
    assign out_imm      = w_m_bundle.imm;
    assign out_pc       = w_m_bundle.pc;

endmodule

// File: tb/tb_id_ex_stage_reg_s.sv
module tb_id_ex_stage_reg_s;
    import id_ex_stage_reg_s_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, in_valid, out_ready;
    logic in_ready, out_valid;
    id_ex_bundle_t cur;

    logic [6:0]  out_op;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_mem_read, out_mem_write, out_reg_write, out_jump, out_branch;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_rs1_data, out_rs2_data, out_imm, out_pc;

    id_ex_bundle_t got;
    assign got = {out_op, out_funct3, out_funct7, out_mem_read, out_mem_write,
                  out_reg_write, out_jump, out_branch, out_rs1, out_rs2, out_rd,
                  out_rs1_data, out_rs2_data, out_imm, out_pc};

    int checks = 0;
    int failures = 0;
    id_ex_bundle_t sb[$];
    id_ex_bundle_t exp_b;

    id_ex_stage_reg_s #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(cur.op), .in_funct3(cur.funct3), .in_funct7(cur.funct7),
        .in_mem_read(cur.mem_read), .in_mem_write(cur.mem_write),
        .in_reg_write(cur.reg_write), .in_jump(cur.jump), .in_branch(cur.branch),
        .in_rs1(cur.rs1), .in_rs2(cur.rs2), .in_rd(cur.rd),
        .in_rs1_data(cur.rs1_data), .in_rs2_data(cur.rs2_data),
        .in_imm(cur.imm), .in_pc(cur.pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_jump(out_jump), .out_branch(out_branch),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_pc(out_pc)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Hand decoding of control bits per opcode.
    function automatic id_ex_bundle_t mk(input logic [6:0] op, input logic [31:0] pc);
        id_ex_bundle_t b;
        b          = '0;
        b.op       = op;
        b.funct3   = pc[4:2];
        b.funct7   = (op == OP_R_TYPE) ? 7'h20 : 7'h00;
        b.rs1      = pc[6:2];
        b.rs2      = pc[6:2] + 5'd1;
        b.rd       = pc[6:2] + 5'd2;
        b.rs1_data = 32'h1000_0000 ^ pc;
        b.rs2_data = 32'hA5A5_0000 + pc;
        b.imm      = {20'h0, pc[11:0]} + 32'd3;
        b.pc       = pc;
        case (op)
            OP_R_TYPE: b.reg_write = 1'b1;
            OP_I_LOAD: begin b.mem_read = 1'b1; b.reg_write = 1'b1; end
            OP_S_TYPE: b.mem_write = 1'b1;
            OP_BRANCH: b.branch = 1'b1;
            OP_JAL:    begin b.jump = 1'b1; b.reg_write = 1'b1; end
            default:   ;
        endcase
        return b;
    endfunction

    // One clock: note handshake before the edge, update the scoreboard at it.
    task automatic step();
        logic acc;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (rst || flush) sb.delete();
        else if (acc) sb.push_back(cur);
        #1;
    endtask

    // Monitor: compares every drained bundle with the scoreboard head.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual_pc=%0h required=none", out_pc);
                end else begin
                    exp_b = sb.pop_front();
                    chk("out_bundle", 256'(got), 256'(exp_b));
                    $display("OUT pc=%08h op=%02h ctrl=%b%b%b%b%b", out_pc, out_op,
                             out_mem_read, out_mem_write, out_reg_write, out_jump, out_branch);
                end
            end
        end else begin
            chk("bubble_ctrl", 256'({out_mem_read, out_mem_write, out_reg_write,
                                     out_jump, out_branch}), 256'(0));
        end
    end

    initial begin
        logic [6:0] ops [0:4];
        ops = '{OP_R_TYPE, OP_I_LOAD, OP_S_TYPE, OP_BRANCH, OP_JAL};

        // Reset held two cycles with an offered load bundle.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; cur = mk(OP_I_LOAD, 32'h40);
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_outputs", 256'(got), 256'(0));

        // Streaming at full rate.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur = mk(ops[i], 32'(i * 4));
            step();
            chk("stream_pc", 256'(out_pc), 256'(i * 4));
            chk("stream_valid", 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", 256'(out_valid), 256'(0));

        // Back-pressure into the skid entry.
        out_ready = 1'b0; in_valid = 1'b1;
        cur = mk(OP_R_TYPE, 32'h10);
        step();
        chk("bp_ready_full", 256'(in_ready), 256'(1));
        chk("bp_pc_first", 256'(out_pc), 256'(32'h10));
        cur = mk(OP_S_TYPE, 32'h14);
        step();
        chk("bp_ready_skid", 256'(in_ready), 256'(0));
        chk("bp_pc_hold", 256'(out_pc), 256'(32'h10));
        chk("bp_memw_r", 256'(out_mem_write), 256'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_pc_second", 256'(out_pc), 256'(32'h14));
        chk("bp_memw_s", 256'(out_mem_write), 256'(1));
        chk("bp_ready_back", 256'(in_ready), 256'(1));
        step();
        chk("bp_empty", 256'(out_valid), 256'(0));

        // Flush in SKID with a same-cycle offer of pc 0x20.
        out_ready = 1'b0; in_valid = 1'b1;
        cur = mk(OP_I_LOAD, 32'h18); step();
        cur = mk(OP_BRANCH, 32'h1C); step();
        chk("fl_skid_ready", 256'(in_ready), 256'(0));
        cur = mk(OP_JAL, 32'h20); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 256'(out_valid), 256'(0));
        chk("fl_ctrl", 256'({out_mem_read, out_mem_write, out_reg_write, out_jump, out_branch}), 256'(0));
        chk("fl_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        step(); step(); step();
        chk("fl_stays_empty", 256'(out_valid), 256'(0));

        // Flush in FULL: offer is not captured although in_ready is high.
        out_ready = 1'b0; in_valid = 1'b1;
        cur = mk(OP_JAL, 32'h24); step();
        chk("flf_pc", 256'(out_pc), 256'(32'h24));
        cur = mk(OP_R_TYPE, 32'h28); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flf_valid", 256'(out_valid), 256'(0));
        chk("flf_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        step(); step();
        chk("flf_stays_empty", 256'(out_valid), 256'(0));

        // Flush and reset together from SKID.
        out_ready = 1'b0; in_valid = 1'b1;
        cur = mk(OP_S_TYPE, 32'h2C); step();
        cur = mk(OP_I_LOAD, 32'h30); step();
        cur = mk(OP_R_TYPE, 32'h34); rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rf_out_valid", 256'(out_valid), 256'(0));
        chk("rf_in_ready", 256'(in_ready), 256'(1));
        chk("rf_outputs", 256'(got), 256'(0));

        // Mixed valid/ready/flush traffic against the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cur       = mk(ops[$urandom_range(0, 4)], 32'h100 + 32'(n * 4));
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) step();
        chk("sb_drained", 256'(sb.size()), 256'(0));
        chk("final_empty", 256'(out_valid), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
